das_channel_accumulator: RTL and testbench
==========================================

Name: das_channel_accumulator

Overview:
- Delay-and-sum reduction stage. Sits directly downstream of the per-channel weighting multiplier, which produces unsigned 20-bit products.
- Accepts one weighted sample per channel as an AXI-Stream-style beat and sums NUM_CH beats into one beam sample.
- Emits the sum on a registered output stream, with a frame-error flag and a saturating error counter.

Parameters:
- DIN_WIDTH, 20, width of the unsigned product input.
- NUM_CH, 8, channels per frame (≥2).
- CNT_WIDTH, 3, channel counter width = ceil(log2(NUM_CH)).
- DOUT_WIDTH, 23, sum width = DIN_WIDTH + CNT_WIDTH.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- din_TDATA  in  DIN_WIDTH  unsigned weighted sample.
- din_TVALID  in  1  input beat valid.
- din_TREADY  out  1  input beat accepted when TVALID&TREADY.
- din_TLAST  in  1  marks the last channel of a frame.
- dout_TDATA  out  DOUT_WIDTH  beam sum, unsigned.
- dout_TVALID  out  1  output valid.
- dout_TREADY  in  1  downstream ready.
- dout_TUSER  out  1  frame error flag for the presented sum.
- err_count  out  16  saturating count of erroneous frames.

Behaviour:
- Reset (ap_rst=1 at an edge): acc=0, cnt=0, dout_TDATA=0, dout_TVALID=0, dout_TUSER=0, err_count=0. din_TREADY=0 while ap_rst=1.
- Reset mid-frame discards the partial sum. A pending output is dropped. No beat is accepted in the reset cycle.
- din_TREADY = ~ap_rst & (~dout_TVALID | dout_TREADY). This is combinational; the input stalls only when the output register is full and not draining.
- States are implied by cnt:
  - EMPTY (cnt=0): next beat starts a frame; sum = din_TDATA.
  - ACCUM (cnt>0): sum = acc + din_TDATA.
- Widths: zero-extend din to DOUT_WIDTH before adding. Overflow is impossible by construction; no saturation.
- Accepted beat, frame close: the beat closes the frame if din_TLAST=1 or cnt=NUM_CH-1. On close:
  - Load dout_TDATA=sum and dout_TVALID=1.
  - dout_TUSER = din_TLAST XOR (cnt==NUM_CH-1). This catches both early TLAST and missing TLAST.
  - Reset acc and cnt to 0.
  - If the error flag is 1, increment err_count, saturating at 0xFFFF.
- Accepted beat, no close: acc=sum, cnt=cnt+1.
- Latency: 1 cycle from the closing input beat to dout_TVALID=1.
- Output handshake:
  - dout_TDATA and dout_TUSER are held stable while TVALID=1 and TREADY=0.
  - Transfer clears dout_TVALID unless a new frame closes in the same cycle. In that case the new sum is loaded and TVALID stays 1 (back-to-back frames at full rate).
- Throughput: one input beat per cycle; one output per NUM_CH cycles when unstalled.
- din_TVALID=0 cycles leave acc and cnt unchanged (bubbles allowed mid-frame).
- din_TDATA and din_TLAST are ignored when not accepted.

Test Plan:
- Basic frame: reset, then 8 beats of values 1..8 with TLAST on the 8th, dout_TREADY=1.
  - Expect one cycle later: dout_TDATA=36, TUSER=0, TVALID high for 1 cycle, err_count=0.
- Max values: 8 beats of 0xFFFFF.
  - Expect dout_TDATA=0x7FFFF8, TUSER=0, no wrap.
- Early TLAST: 3 beats of 10 with TLAST on the 3rd, then a correct 8-beat frame of 1s.
  - Expect first output 30 with TUSER=1, err_count=1.
  - Expect second output 8 with TUSER=0.
- Missing TLAST: 8 beats of 5 with TLAST=0.
  - Expect output 40, TUSER=1, err_count increments.
  - The 9th beat starts a new frame (cnt=0).
- Backpressure: hold dout_TREADY=0 after a frame closes.
  - Expect dout_TDATA stable and din_TREADY=0 until dout_TREADY=1.
  - Then the transfer completes and, if a frame closes in the same cycle, TVALID stays high with the new sum.
- Reset mid-frame: 4 beats of 100, assert ap_rst for 1 cycle, then a full frame of 2s.
  - Expect a single output of 16 (the partial sum is lost) and err_count=0.

Source files
------------

// File: rtl/das_channel_accumulator.sv
// das_channel_accumulator
// Delay-and-sum reduction stage: sums NUM_CH unsigned weighted channel samples
// (one AXI-Stream beat per channel) into a single beam sample.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst       synchronous active-high reset
//   din_TDATA    unsigned weighted sample
//   din_TVALID   input beat valid
//   din_TREADY   input ready (combinational, stalls only when output is full and blocked)
//   din_TLAST    last channel of a frame
//   dout_TDATA   registered beam sum
//   dout_TVALID  output valid
//   dout_TREADY  downstream ready
//   dout_TUSER   frame error for the presented sum (early or missing TLAST)
//   err_count    saturating count of erroneous frames
module das_channel_accumulator #(
  parameter int unsigned DIN_WIDTH  = 20,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(NUM_CH),
  parameter int unsigned DOUT_WIDTH = DIN_WIDTH + CNT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DIN_WIDTH-1:0]  din_TDATA,
  input  logic                  din_TVALID,
  output logic                  din_TREADY,
  input  logic                  din_TLAST,
  output logic [DOUT_WIDTH-1:0] dout_TDATA,
  output logic                  dout_TVALID,
  input  logic                  dout_TREADY,
  output logic                  dout_TUSER,
  output logic [15:0]           err_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_CH = CNT_WIDTH'(NUM_CH - 1);

  logic [DOUT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DOUT_WIDTH-1:0] r_dout_data;
  logic                  r_dout_valid;
  logic                  r_dout_user;
  logic [15:0]           r_err_count;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_last_ch;
  logic                  w_close;
  logic                  w_err;
  logic [DOUT_WIDTH-1:0] w_din_ext;
  logic [DOUT_WIDTH-1:0] w_sum;

  // Input is only blocked when the output register holds a sum nobody is taking.
  assign w_ready   = ~ap_rst & (~r_dout_valid | dout_TREADY);
  assign w_accept  = din_TVALID & w_ready;
  assign w_last_ch = (r_cnt == LAST_CH);
  // A frame closes on TLAST or on the final channel, whichever comes first.
  assign w_close   = w_accept & (din_TLAST | w_last_ch);
  // Mismatch between TLAST and channel position flags early or missing TLAST.
  assign w_err     = din_TLAST ^ w_last_ch;
  assign w_din_ext = DOUT_WIDTH'(din_TDATA);
  assign w_sum     = (r_cnt == '0) ? w_din_ext : (r_acc + w_din_ext);

  // Accumulator, channel counter and registered output stream.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_dout_data  <= '0;
      r_dout_valid <= 1'b0;
      r_dout_user  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      if (r_dout_valid && dout_TREADY) begin
        r_dout_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_close) begin
          r_dout_data  <= w_sum;
          r_dout_valid <= 1'b1;
          r_dout_user  <= w_err;
          r_acc        <= '0;
          r_cnt        <= '0;
          if (w_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
          end
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign din_TREADY  = w_ready;
  assign dout_TDATA  = r_dout_data;
  assign dout_TVALID = r_dout_valid;
  assign dout_TUSER  = r_dout_user;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_das_channel_accumulator.sv
// Directed testbench for das_channel_accumulator (NUM_CH=8, 20-bit input).
module tb_das_channel_accumulator;

  logic        ap_clk;
  logic        ap_rst;
  logic [19:0] din_TDATA;
  logic        din_TVALID;
  logic        din_TREADY;
  logic        din_TLAST;
  logic [22:0] dout_TDATA;
  logic        dout_TVALID;
  logic        dout_TREADY;
  logic        dout_TUSER;
  logic [15:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  das_channel_accumulator dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .din_TDATA   (din_TDATA),
    .din_TVALID  (din_TVALID),
    .din_TREADY  (din_TREADY),
    .din_TLAST   (din_TLAST),
    .dout_TDATA  (dout_TDATA),
    .dout_TVALID (dout_TVALID),
    .dout_TREADY (dout_TREADY),
    .dout_TUSER  (dout_TUSER),
    .err_count   (err_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat for one clock edge; inputs settle 1 time unit after the edge.
  task automatic beat(input logic [19:0] d, input logic last);
    din_TDATA  = d;
    din_TLAST  = last;
    din_TVALID = 1'b1;
    @(posedge ap_clk); #1;
    din_TVALID = 1'b0;
    din_TLAST  = 1'b0;
  endtask

  task automatic idle();
    @(posedge ap_clk); #1;
  endtask

  task automatic check_out(input string tag, input logic [22:0] data,
                           input logic user, input logic [15:0] errs);
    check({tag, "_valid"}, 32'(dout_TVALID), 32'd1);
    check({tag, "_data"},  32'(dout_TDATA),  32'(data));
    check({tag, "_user"},  32'(dout_TUSER),  32'(user));
    check({tag, "_errs"},  32'(err_count),   32'(errs));
  endtask

  initial begin
    ap_rst      = 1'b1;
    din_TDATA   = '0;
    din_TVALID  = 1'b0;
    din_TLAST   = 1'b0;
    dout_TREADY = 1'b1;

    // Reset state
    idle(); idle();
    check("rst_valid", 32'(dout_TVALID), 32'd0);
    check("rst_data",  32'(dout_TDATA),  32'd0);
    check("rst_user",  32'(dout_TUSER),  32'd0);
    check("rst_errs",  32'(err_count),   32'd0);
    check("rst_ready", 32'(din_TREADY),  32'd0);
    ap_rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(din_TREADY), 32'd1);

    // Basic frame 1..8 -> 36
    for (int i = 1; i <= 8; i++) beat(20'(i), i == 8);
    check_out("basic", 23'd36, 1'b0, 16'd0);
    idle();
    check("basic_one_cycle", 32'(dout_TVALID), 32'd0);

    // Max values with a mid-frame bubble -> 0x7FFFF8
    for (int i = 1; i <= 8; i++) begin
      beat(20'hFFFFF, i == 8);
      if (i == 4) begin idle(); idle(); end
    end
    check_out("max", 23'h7FFFF8, 1'b0, 16'd0);
    idle();

    // Early TLAST: 3 x 10 -> 30 flagged, then 8 x 1 -> 8 clean
    for (int i = 1; i <= 3; i++) beat(20'd10, i == 3);
    check_out("early", 23'd30, 1'b1, 16'd1);
    for (int i = 1; i <= 8; i++) beat(20'd1, i == 8);
    check_out("after_early", 23'd8, 1'b0, 16'd1);
    idle();

    // Missing TLAST: 8 x 5 -> 40 flagged; 9th beat starts a new frame
    for (int i = 1; i <= 8; i++) beat(20'd5, 1'b0);
    check_out("missing", 23'd40, 1'b1, 16'd2);
    beat(20'd3, 1'b0);
    check("new_frame_no_out", 32'(dout_TVALID), 32'd0);
    for (int i = 2; i <= 8; i++) beat(20'd3, i == 8);
    check_out("after_missing", 23'd24, 1'b0, 16'd2);
    idle();

    // Backpressure: held output stalls input; drain coincides with a 1-beat close
    dout_TREADY = 1'b0;
    for (int i = 1; i <= 8; i++) beat(20'd4, i == 8);
    check_out("bp_hold", 23'd32, 1'b0, 16'd2);
    check("bp_in_stall", 32'(din_TREADY), 32'd0);
    din_TDATA  = 20'd9;
    din_TLAST  = 1'b1;
    din_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("bp_data_stable", 32'(dout_TDATA),  32'd32);
      check("bp_valid_held",  32'(dout_TVALID), 32'd1);
      check("bp_in_stall2",   32'(din_TREADY),  32'd0);
    end
    dout_TREADY = 1'b1;
    #1;
    check("bp_in_release", 32'(din_TREADY), 32'd1);
    idle();
    din_TVALID = 1'b0;
    din_TLAST  = 1'b0;
    check_out("bp_b2b", 23'd9, 1'b1, 16'd3);
    idle();
    check("bp_drained", 32'(dout_TVALID), 32'd0);

    // Reset mid-frame: partial sum of 4 x 100 is lost
    for (int i = 0; i < 4; i++) beat(20'd100, 1'b0);
    ap_rst     = 1'b1;
    din_TDATA  = 20'd100;
    din_TVALID = 1'b1;
    #1;
    check("rst_mid_ready", 32'(din_TREADY), 32'd0);
    idle();
    ap_rst     = 1'b0;
    din_TVALID = 1'b0;
    check("rst_mid_valid", 32'(dout_TVALID), 32'd0);
    check("rst_mid_errs",  32'(err_count),   32'd0);
    for (int i = 1; i <= 8; i++) beat(20'd2, i == 8);
    check_out("rst_mid", 23'd16, 1'b0, 16'd0);
    idle();
    check("rst_mid_single", 32'(dout_TVALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
